npu_if_region_ctrl: RTL and testbench
=====================================

Name: npu_if_region_ctrl

Overview:
Parametrised next-generation NPU bus slave interface. It decodes a bus address window into NumRegions memory regions, each backed by an SRAM with configurable read latency. It inserts wait states for slow reads and for read-after-write port collisions, and returns two-cycle ERROR responses for unmapped addresses and for writes to read-only regions. It sits between the system bus and the NPU local memories (input, type, weight and output buffers).

Parameters:
DWidth, 32, bus and memory data/address width
NumRegions, 4, number of decoded memory regions; power of two, ≥2
RegionAw, 14, offset bits per region (word-addressed slice addr[RegionAw-1:0] forwarded)
BaseTag, 'h0002, required value of addr[DWidth-1:RegionAw+$clog2(NumRegions)]
ReadLatency, 2, SRAM read latency in cycles, ≥1
RoMask, 4'b1000, bit r set → region r is read-only

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
sel_i  in  1  slave select
trans_i  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
ready_i  in  1  bus-wide ready; an address phase is accepted only when it is high
write_i  in  1  1=write, 0=read
addr_i  in  DWidth  address-phase address
wdata_i  in  DWidth  write data, valid in the data phase
mem_req_o  out  NumRegions  one-hot region access strobe
mem_we_o  out  1  write enable qualifying mem_req_o
mem_addr_o  out  RegionAw  region offset
mem_wdata_o  out  DWidth  write data to memory
mem_rdata_i  in  NumRegions*DWidth  concatenated region read data; region r is slice [r*DWidth +: DWidth]
rdata_o  out  DWidth  read data to master
resp_o  out  1  0=OKAY, 1=ERROR
ready_o  out  1  slave ready

Behaviour:
- Accept condition: sel_i & ready_i & trans_i∈{NONSEQ,SEQ}. IDLE/BUSY transfers, or an unselected slave, get a zero-wait OKAY.
- Decode: region index = addr[RegionAw+$clog2(NumRegions)-1:RegionAw]. Address is unmapped if the tag ≠ BaseTag. It is an error if it is unmapped, or if it is a write with RoMask[idx]=1.
- FSM states:
  - ST_IDLE
  - ST_WRITE: 1-cycle write data phase
  - ST_RDWAIT: latency counter
  - ST_RDDEFER: deferred read issue
  - ST_ERR1
  - ST_ERR2
- ST_RDWAIT, ST_RDDEFER and ST_ERR1 drive ready_o=0, so no new address is accepted in those states. ST_IDLE, ST_WRITE and ST_ERR2 drive ready_o=1 and may accept the next address phase.
- Write: address accepted at cycle T; region and offset registered. At T+1 (ST_WRITE): mem_req_o[r]=1, mem_we_o=1, mem_addr_o=registered offset, mem_wdata_o=wdata_i, ready_o=1, resp_o=0. No wait states.
- Read, no collision: at accept cycle T, mem_req_o[r]=1 and mem_addr_o=addr_i offset, issued combinationally. For T+1..T+ReadLatency-1, ready_o=0. At T+ReadLatency, ready_o=1 and rdata_o=mem_rdata_i slice r, latched into a holding register. ReadLatency=1 gives zero wait states.
- Read/write collision: if a read is accepted during an ST_WRITE cycle, the write owns the memory port. The read address is registered and issued at T+1 (ST_RDDEFER). That read's data phase gains one extra wait state, with data at T+ReadLatency+1.
- Error: no mem_req_o asserted. The data phase is:
  - ST_ERR1: ready_o=0, resp_o=1.
  - ST_ERR2: ready_o=1, resp_o=1.
- Outside a read-completion cycle, rdata_o holds the last latched read data.
- mem_req_o is at most one-hot. mem_req_o and mem_we_o are 0 whenever no access is issued.
- Latency counter width is $clog2(ReadLatency+2). It saturates only by FSM exit, with no wrap.
- Reset, including mid-transfer: state returns to ST_IDLE. ready_o=1, resp_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, counter=0. A pending write is dropped, not issued.

Test Plan (defaults):
1. Write NONSEQ 0x0002_4010, data 0xDEADBEEF → next cycle: mem_req_o=4'b0010, mem_we_o=1, mem_addr_o=0x0010, mem_wdata_o=0xDEADBEEF, ready_o=1, resp_o=0.
2. Read 0x0002_0004, region 0 returns 0x1234_5678 two cycles after the request → ready_o=0 for 1 cycle, then ready_o=1 and rdata_o=0x1234_5678; rdata_o holds that value through following idle cycles.
3. Write 0x0002_0000 immediately followed by read 0x0002_8008 → write issued first. Read request (mem_req_o=4'b0100, mem_addr_o=0x0008) is one cycle later; ready_o=0 for 2 cycles before the data.
4. Write to read-only region 0x0002_C000 → no mem_req_o. ready_o/resp_o sequence is 0/1 then 1/1.
5. Read unmapped 0x0003_0000 → ERROR two-cycle response, no memory access. A following valid read to 0x0002_0000 completes OKAY.
6. Assert rst_ni=0 during a read wait state → outputs return to reset values immediately. After release, a write to 0x0002_4000 completes normally.

Source files
------------

// File: rtl/npu_if_region_ctrl.sv
// Bus slave that decodes an address window into NumRegions SRAM-backed regions, inserting read
// wait states, deferring reads that collide with a write data phase, and giving two-cycle ERRORs.
module npu_if_region_ctrl #(
    parameter int unsigned           DWidth      = 32,
    parameter int unsigned           NumRegions  = 4,
    parameter int unsigned           RegionAw    = 14,
    parameter logic [DWidth-1:0]     BaseTag     = 'h0002,
    parameter int unsigned           ReadLatency = 2,
    parameter logic [NumRegions-1:0] RoMask      = 4'b1000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sel_i,
    input  logic [1:0]                   trans_i,
    input  logic                         ready_i,
    input  logic                         write_i,
    input  logic [DWidth-1:0]            addr_i,
    input  logic [DWidth-1:0]            wdata_i,
    output logic [NumRegions-1:0]        mem_req_o,
    output logic                         mem_we_o,
    output logic [RegionAw-1:0]          mem_addr_o,
    output logic [DWidth-1:0]            mem_wdata_o,
    input  logic [NumRegions*DWidth-1:0] mem_rdata_i,
    output logic [DWidth-1:0]            rdata_o,
    output logic                         resp_o,
    output logic                         ready_o
);

    localparam int unsigned IdxW   = $clog2(NumRegions);
    localparam int unsigned TagLsb = RegionAw + IdxW;
    localparam int unsigned TagW   = DWidth - TagLsb;
    localparam int unsigned CntW   = $clog2(ReadLatency + 2);

    localparam logic [TagW-1:0] TagVal      = BaseTag[TagW-1:0];
    localparam logic [CntW-1:0] LastCnt     = CntW'(ReadLatency - 1);
    localparam logic [1:0]      TransNonseq = 2'b10;
    localparam logic [1:0]      TransSeq    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RDWAIT,
        ST_RDDEFER,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                state_q;
    logic                  ready_q;
    logic                  resp_q;
    logic [CntW-1:0]       cnt_q;
    logic                  rdValid_q;
    logic [IdxW-1:0]       wrRegion_q;
    logic [RegionAw-1:0]   wrOffset_q;
    logic [IdxW-1:0]       rdRegion_q;
    logic [RegionAw-1:0]   rdOffset_q;
    logic [DWidth-1:0]     rdataHold_q;

    logic [IdxW-1:0]       addrIdx;
    logic [RegionAw-1:0]   addrOff;
    logic [TagW-1:0]       addrTag;
    logic                  activeTrans;
    logic                  accept;
    logic                  isErr;
    logic                  issueNow;
    logic [DWidth-1:0]     rdSlice;
    logic [NumRegions-1:0] memReq;
    logic                  memWe;
    logic [RegionAw-1:0]   memAddr;

    assign addrIdx = addr_i[TagLsb-1:RegionAw];
    assign addrOff = addr_i[RegionAw-1:0];
    assign addrTag = addr_i[DWidth-1:TagLsb];

    // Only states with ready_o high take a new address phase; reset also blocks acceptance so
    // no strobe can leak out while rst_ni is held low.
    assign activeTrans = (trans_i == TransNonseq) || (trans_i == TransSeq);
    assign accept      = rst_ni & sel_i & ready_i & activeTrans & ready_q;
    assign isErr       = (addrTag != TagVal) | (write_i & RoMask[addrIdx]);
    assign issueNow    = accept & ~isErr & ~write_i & (state_q != ST_WRITE);

    assign rdSlice = mem_rdata_i[rdRegion_q*DWidth +: DWidth];

    // The write data phase owns the port, then a deferred read, otherwise a fresh read is
    // issued straight from the address phase.
    always_comb begin
        memReq  = '0;
        memWe   = 1'b0;
        memAddr = '0;
        if (state_q == ST_WRITE) begin
            memReq[wrRegion_q] = 1'b1;
            memWe              = 1'b1;
            memAddr            = wrOffset_q;
        end else if (state_q == ST_RDDEFER) begin
            memReq[rdRegion_q] = 1'b1;
            memAddr            = rdOffset_q;
        end else if (issueNow) begin
            memReq[addrIdx] = 1'b1;
            memAddr         = addrOff;
        end
    end

    assign mem_req_o   = memReq;
    assign mem_we_o    = memWe;
    assign mem_addr_o  = memAddr;
    assign mem_wdata_o = wdata_i;
    assign rdata_o     = rdValid_q ? rdSlice : rdataHold_q;
    assign ready_o     = ready_q;
    assign resp_o      = resp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            resp_q      <= 1'b0;
            cnt_q       <= '0;
            rdValid_q   <= 1'b0;
            wrRegion_q  <= '0;
            wrOffset_q  <= '0;
            rdRegion_q  <= '0;
            rdOffset_q  <= '0;
            rdataHold_q <= '0;
        end else begin
            rdValid_q <= 1'b0;
            if (rdValid_q) begin
                rdataHold_q <= rdSlice;
            end
            case (state_q)
                ST_RDWAIT: begin
                    if (cnt_q == LastCnt) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        rdValid_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_RDDEFER: begin
                    resp_q <= 1'b0;
                    if (ReadLatency == 1) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        rdValid_q <= 1'b1;
                    end else begin
                        state_q <= ST_RDWAIT;
                        ready_q <= 1'b0;
                        cnt_q   <= CntW'(1);
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                ST_IDLE, ST_WRITE, ST_ERR2: begin
                    if (!accept) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end else if (isErr) begin
                        state_q <= ST_ERR1;
                        ready_q <= 1'b0;
                        resp_q  <= 1'b1;
                    end else if (write_i) begin
                        state_q    <= ST_WRITE;
                        ready_q    <= 1'b1;
                        resp_q     <= 1'b0;
                        wrRegion_q <= addrIdx;
                        wrOffset_q <= addrOff;
                    end else if (state_q == ST_WRITE) begin
                        state_q    <= ST_RDDEFER;
                        ready_q    <= 1'b0;
                        resp_q     <= 1'b0;
                        rdRegion_q <= addrIdx;
                        rdOffset_q <= addrOff;
                    end else begin
                        resp_q     <= 1'b0;
                        rdRegion_q <= addrIdx;
                        rdOffset_q <= addrOff;
                        if (ReadLatency == 1) begin
                            state_q   <= ST_IDLE;
                            ready_q   <= 1'b1;
                            rdValid_q <= 1'b1;
                        end else begin
                            state_q <= ST_RDWAIT;
                            ready_q <= 1'b0;
                            cnt_q   <= CntW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Sanity properties on the memory-side strobes.
    memReqOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(mem_req_o));
    memWeQualified: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     mem_we_o |-> (mem_req_o != '0));

endmodule

// File: tb/tb_npu_if_region_ctrl.sv
// Directed bench for npu_if_region_ctrl: a vector table for the main transfers plus hand-written
// reset-in-flight sequences, against a simple per-region SRAM model with two-cycle read latency.
module tb_npu_if_region_ctrl;

    logic         clk_i;
    logic         rst_ni;
    logic         sel_i;
    logic [1:0]   trans_i;
    logic         ready_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [3:0]   mem_req_o;
    logic         mem_we_o;
    logic [13:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic [31:0]  rdata_o;
    logic         resp_o;
    logic         ready_o;

    int vecCount  = 0;
    int missCount = 0;

    npu_if_region_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sel_i       (sel_i),
        .trans_i     (trans_i),
        .ready_i     (ready_i),
        .write_i     (write_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .resp_o      (resp_o),
        .ready_o     (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM model: word i of region r holds 0xA00r_00ii, except region 0 word 4; data appears
    // two cycles after a read strobe and stays until the next read of that region.
    logic [31:0] mem [4][64];
    logic [31:0] stage1 [4];
    logic [31:0] stage2 [4];

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < 4; r++) begin
                stage1[r] <= 32'h0;
                stage2[r] <= 32'h0;
                for (int i = 0; i < 64; i++) begin
                    mem[r][i] <= 32'hA000_0000 + 32'(r) * 32'h1_0000 + 32'(i);
                end
            end
            mem[0][4] <= 32'h1234_5678;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (mem_req_o[r] && mem_we_o) begin
                    mem[r][mem_addr_o[5:0]] <= mem_wdata_o;
                end else if (mem_req_o[r]) begin
                    stage1[r] <= mem[r][mem_addr_o[5:0]];
                end
                stage2[r] <= stage1[r];
            end
        end
    end

    always_comb begin
        mem_rdata_i = '0;
        for (int r = 0; r < 4; r++) begin
            mem_rdata_i[r*32 +: 32] = stage2[r];
        end
    end

    typedef struct {
        string       name;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  expReq;
        logic        expWe;
        logic [13:0] expAddr;
        logic        expRdy;
        logic        expResp;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic s, logic [1:0] t, logic w, logic [31:0] a,
                                logic [31:0] wd, logic [3:0] eReq, logic eWe, logic [13:0] eAddr,
                                logic eRdy, logic eResp, logic [31:0] eRd);
        vec_t v;
        v.name = n; v.sel = s; v.trans = t; v.wr = w; v.addr = a; v.wdata = wd;
        v.expReq = eReq; v.expWe = eWe; v.expAddr = eAddr;
        v.expRdy = eRdy; v.expResp = eResp; v.expRdata = eRd;
        return v;
    endfunction

    task automatic applyStimulus(input logic s, input logic [1:0] t, input logic w,
                                 input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        sel_i   = s;
        trans_i = t;
        write_i = w;
        addr_i  = a;
        wdata_i = wd;
        ready_i = rdy;
    endtask

    task automatic checkOutput(input string n, input logic [3:0] eReq, input logic eWe,
                               input logic [13:0] eAddr, input logic [31:0] eWdata,
                               input logic eRdy, input logic eResp, input logic [31:0] eRd);
        logic ok;
        ok = (mem_req_o === eReq) && (mem_we_o === eWe) && (ready_o === eRdy) &&
             (resp_o === eResp) && (rdata_o === eRd) &&
             ((eReq == 4'b0) || (mem_addr_o === eAddr)) &&
             (!eWe || (mem_wdata_o === eWdata));
        vecCount++;
        if (!ok) begin
            missCount++;
            $display("[TB] FAIL %s: got req=%b we=%b addr=%h wdata=%h rdy=%b resp=%b rdata=%h, want req=%b we=%b addr=%h wdata=%h rdy=%b resp=%b rdata=%h",
                     n, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ready_o, resp_o, rdata_o,
                     eReq, eWe, eAddr, eWdata, eRdy, eResp, eRd);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);

        vecs.push_back(mk("rst_idle",      0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h0));
        vecs.push_back(mk("t1_wr_addr",    1, 2'b10, 1, 32'h0002_4010, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h0));
        vecs.push_back(mk("t1_wr_data",    0, 2'b00, 0, 32'h0,         32'hDEAD_BEEF, 4'b0010, 1, 14'h0010, 1, 0, 32'h0));
        vecs.push_back(mk("t2_rd_addr",    1, 2'b10, 0, 32'h0002_0004, 32'h0,         4'b0001, 0, 14'h0004, 1, 0, 32'h0));
        vecs.push_back(mk("t2_rd_wait",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    0, 0, 32'h0));
        vecs.push_back(mk("t2_rd_data",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h1234_5678));
        vecs.push_back(mk("t2_hold1",      0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h1234_5678));
        vecs.push_back(mk("t2_hold2",      0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h1234_5678));
        vecs.push_back(mk("t3_wr_addr",    1, 2'b10, 1, 32'h0002_0000, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'h1234_5678));
        vecs.push_back(mk("t3_rd_addr",    1, 2'b10, 0, 32'h0002_8008, 32'hCAFE_F00D, 4'b0001, 1, 14'h0000, 1, 0, 32'h1234_5678));
        vecs.push_back(mk("t3_rd_defer",   0, 2'b00, 0, 32'h0,         32'h0,         4'b0100, 0, 14'h0008, 0, 0, 32'h1234_5678));
        vecs.push_back(mk("t3_rd_wait",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    0, 0, 32'h1234_5678));
        vecs.push_back(mk("t3_rd_data",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hA002_0008));
        vecs.push_back(mk("t4_ro_addr",    1, 2'b10, 1, 32'h0002_C000, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hA002_0008));
        vecs.push_back(mk("t4_err1",       0, 2'b00, 0, 32'h0,         32'h55AA_55AA, 4'b0000, 0, 14'h0,    0, 1, 32'hA002_0008));
        vecs.push_back(mk("t4_err2",       0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 1, 32'hA002_0008));
        vecs.push_back(mk("t5_unmap_addr", 1, 2'b10, 0, 32'h0003_0000, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hA002_0008));
        vecs.push_back(mk("t5_err1",       0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    0, 1, 32'hA002_0008));
        vecs.push_back(mk("t5_err2_rd",    1, 2'b10, 0, 32'h0002_0000, 32'h0,         4'b0001, 0, 14'h0000, 1, 1, 32'hA002_0008));
        vecs.push_back(mk("t5_rd_wait",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    0, 0, 32'hA002_0008));
        vecs.push_back(mk("t5_rd_data",    0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("busy_wr",       1, 2'b01, 1, 32'h0002_4000, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("busy_after",    0, 2'b00, 0, 32'h0,         32'h1111_2222, 4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("seq_wr_addr",   1, 2'b11, 1, 32'h0002_4004, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("seq_wr_data",   0, 2'b00, 0, 32'h0,         32'h0BAD_F00D, 4'b0010, 1, 14'h0004, 1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("unsel_rd",      0, 2'b10, 0, 32'h0002_0004, 32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("unsel_after",   0, 2'b00, 0, 32'h0,         32'h0,         4'b0000, 0, 14'h0,    1, 0, 32'hCAFE_F00D));

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdy);
            @(negedge clk_i);
            checkOutput(vecs[i].name, vecs[i].expReq, vecs[i].expWe, vecs[i].expAddr,
                        vecs[i].wdata, vecs[i].expRdy, vecs[i].expResp, vecs[i].expRdata);
            @(posedge clk_i);
            #1;
        end

        // Reset asserted during a read wait state clears outputs immediately.
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0002_0004, 32'h0, 1'b1);
        @(negedge clk_i);
        checkOutput("t6_rd_addr", 4'b0001, 1'b0, 14'h0004, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        checkOutput("t6_rd_wait", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("t6_rst_async", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        checkOutput("t6_rst_held", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst_ni = 1'b1;

        // After release a write completes, and a write pending at reset is dropped.
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0002_4000, 32'h0, 1'b1);
        @(negedge clk_i);
        checkOutput("t6_wr_addr", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0002_4008, 32'h600D_F00D, 1'b1);
        @(negedge clk_i);
        checkOutput("t6_wr_data", 4'b0010, 1'b1, 14'h0000, 32'h600D_F00D, 1'b1, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h7777_7777, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("t6_rst_drops_wr", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("t6_after_rst", 4'b0000, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
